// File: rtl/display_timing_pkg.sv
// Mode presets and sizing helper shared by the raster timing generator.
package display_timing_pkg;

    // 640x480 at 60 Hz
    localparam int unsigned P480_H_ACTIVE = 640;
    localparam int unsigned P480_H_FP     = 16;
    localparam int unsigned P480_H_SYNC   = 96;
    localparam int unsigned P480_H_BP     = 48;
    localparam int unsigned P480_V_ACTIVE = 480;
    localparam int unsigned P480_V_FP     = 10;
    localparam int unsigned P480_V_SYNC   = 2;
    localparam int unsigned P480_V_BP     = 33;
    localparam bit          P480_H_POL    = 1'b0;
    localparam bit          P480_V_POL    = 1'b0;

    // 1280x720 at 60 Hz
    localparam int unsigned P720_H_ACTIVE = 1280;
    localparam int unsigned P720_H_FP     = 110;
    localparam int unsigned P720_H_SYNC   = 40;
    localparam int unsigned P720_H_BP     = 220;
    localparam int unsigned P720_V_ACTIVE = 720;
    localparam int unsigned P720_V_FP     = 5;
    localparam int unsigned P720_V_SYNC   = 5;
    localparam int unsigned P720_V_BP     = 20;
    localparam bit          P720_H_POL    = 1'b1;
    localparam bit          P720_V_POL    = 1'b1;

    // Smallest coordinate width whose range covers both totals.
    function automatic int unsigned calc_cw(input int unsigned h_total, input int unsigned v_total);
        int unsigned m;
        int unsigned w;
        m = (h_total > v_total) ? h_total : v_total;
        w = 1;
        while ((w < 31) && ((32'd1 << w) < m))
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/display_axis_counter.sv
// Wrap counter for one raster axis; resets to MAX so the first advance lands on 0.
module display_axis_counter #(
    parameter int unsigned MAX = 799,
    parameter int unsigned W   = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    logic at_max;

    always_comb begin
        at_max = (count == W'(MAX));
        wrap   = en && at_max;
        if (!en)
            count_next = count;
        else if (at_max)
            count_next = '0;
        else
            count_next = count + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count <= W'(MAX);
        else
            count <= count_next;
    end

endmodule

// File: rtl/display_timings_param.sv
// Parametrised raster timing generator: coordinates, syncs, data enable, strobes, frame count.
module display_timings_param
    import display_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = P480_H_ACTIVE,
    parameter int unsigned H_FP     = P480_H_FP,
    parameter int unsigned H_SYNC   = P480_H_SYNC,
    parameter int unsigned H_BP     = P480_H_BP,
    parameter int unsigned V_ACTIVE = P480_V_ACTIVE,
    parameter int unsigned V_FP     = P480_V_FP,
    parameter int unsigned V_SYNC   = P480_V_SYNC,
    parameter int unsigned V_BP     = P480_V_BP,
    parameter bit          H_POL    = P480_H_POL,
    parameter bit          V_POL    = P480_V_POL,
    parameter int unsigned CW       = 10,
    parameter int unsigned FW       = 16
) (
    input  logic          clk_pix,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] HS_STA = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_STA = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);

    if (calc_cw(H_TOTAL, V_TOTAL) > CW) begin : g_cw_too_small
        $error("display_timings_param: CW cannot hold the raster totals");
    end

    logic [CW-1:0] sx_next;
    logic [CW-1:0] sy_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_act;
    logic          vs_act;

    display_axis_counter #(.MAX(H_TOTAL - 1), .W(CW)) u_h_cnt (
        .clk        (clk_pix),
        .rst        (rst),
        .en         (ce),
        .count      (sx),
        .count_next (sx_next),
        .wrap       (h_wrap)
    );

    display_axis_counter #(.MAX(V_TOTAL - 1), .W(CW)) u_v_cnt (
        .clk        (clk_pix),
        .rst        (rst),
        .en         (ce && h_wrap),
        .count      (sy),
        .count_next (sy_next),
        .wrap       (v_wrap)
    );

    // Decode from the next coordinates so registered outputs line up with sx/sy.
    always_comb begin
        hs_act = (sx_next >= HS_STA) && (sx_next < HS_END);
        vs_act = (sy_next >= VS_STA) && (sy_next < VS_END);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            hsync        <= ~H_POL;
            vsync        <= ~V_POL;
            de           <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            hsync        <= hs_act ? H_POL : ~H_POL;
            vsync        <= vs_act ? V_POL : ~V_POL;
            de           <= (sx_next < HA) && (sy_next < VA);
            line_start   <= h_wrap;
            frame_start  <= v_wrap;
            vblank_start <= h_wrap && (sy_next == VA);
            if (v_wrap)
                frame_cnt <= frame_cnt + FW'(1);
        end
    end

endmodule

// File: tb/tb_display_timings_param.sv
// Bench for display_timings_param: a small mode with a scoreboard, plus 480p and 720p line checks.
module tb_display_timings_param;
    import display_timing_pkg::*;

    typedef struct packed {
        logic [4:0] sx;
        logic [4:0] sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       vb;
        logic [1:0] cnt;
    } out_t;

    typedef struct {
        logic rst;
        logic ce;
        out_t exp;
    } vec_t;

    // Small mode: 16x12 total, hsync 10..12, vsync lines 8..9, active 8x6.
    localparam int HT = 16;
    localparam int VT = 12;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_s = 1'b1, ce_s = 1'b0;
    logic [4:0] s_sx, s_sy;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
    logic [1:0] s_cnt;

    logic       rst_d = 1'b1, ce_d = 1'b0;
    logic [9:0] d_sx, d_sy;
    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [15:0] d_cnt;

    logic        rst_h = 1'b1, ce_h = 1'b0;
    logic [10:0] h_sx, h_sy;
    logic        h_hs, h_vs, h_de, h_ls, h_fs, h_vb;
    logic [15:0] h_cnt;

    display_timings_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .CW(5), .FW(2)
    ) dut_s (
        .clk_pix(clk), .rst(rst_s), .ce(ce_s), .sx(s_sx), .sy(s_sy),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .line_start(s_ls),
        .frame_start(s_fs), .vblank_start(s_vb), .frame_cnt(s_cnt)
    );

    display_timings_param dut_d (
        .clk_pix(clk), .rst(rst_d), .ce(ce_d), .sx(d_sx), .sy(d_sy),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .line_start(d_ls),
        .frame_start(d_fs), .vblank_start(d_vb), .frame_cnt(d_cnt)
    );

    display_timings_param #(
        .H_ACTIVE(P720_H_ACTIVE), .H_FP(P720_H_FP), .H_SYNC(P720_H_SYNC), .H_BP(P720_H_BP),
        .V_ACTIVE(P720_V_ACTIVE), .V_FP(P720_V_FP), .V_SYNC(P720_V_SYNC), .V_BP(P720_V_BP),
        .H_POL(P720_H_POL), .V_POL(P720_V_POL), .CW(11), .FW(16)
    ) dut_h (
        .clk_pix(clk), .rst(rst_h), .ce(ce_h), .sx(h_sx), .sy(h_sy),
        .hsync(h_hs), .vsync(h_vs), .de(h_de), .line_start(h_ls),
        .frame_start(h_fs), .vblank_start(h_vb), .frame_cnt(h_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic out_t mk(input int sx, input int sy, input bit hs, input bit vs, input bit de,
                                input bit ls, input bit fs, input bit vb, input int cnt);
        out_t o;
        o.sx = 5'(sx); o.sy = 5'(sy); o.hs = hs; o.vs = vs; o.de = de;
        o.ls = ls; o.fs = fs; o.vb = vb; o.cnt = 2'(cnt);
        return o;
    endfunction

    function automatic logic [63:0] mkd(input int unsigned sx, input int unsigned sy, input bit hs,
                                        input bit vs, input bit de, input bit ls, input bit fs,
                                        input bit vb, input int unsigned cnt);
        return {10'd0, 16'(sx), 16'(sy), hs, vs, de, ls, fs, vb, 16'(cnt)};
    endfunction

    // Reference model: position as a linear index into the frame.
    int   mt = 0, mcnt = 0;
    bit   mls = 0, mfs = 0, mvb = 0;
    out_t sbq[$];
    out_t last;
    int   cyc = 0;

    function automatic out_t model_out();
        int sx, sy;
        sx = mt % HT;
        sy = mt / HT;
        return mk(sx, sy, !(sx >= 10 && sx < 13), !(sy >= 8 && sy < 10), (sx < 8) && (sy < 6),
                  mls, mfs, mvb, mcnt);
    endfunction

    task automatic step_s(input logic rst, input logic ce, input bit use_tbl, input out_t texp);
        out_t got, exp;
        @(negedge clk);
        rst_s = rst;
        ce_s  = ce;
        if (rst) begin
            mt = FR - 1; mcnt = 0; mls = 0; mfs = 0; mvb = 0;
        end else if (ce) begin
            mt  = (mt + 1) % FR;
            mls = (mt % HT) == 0;
            mfs = (mt == 0);
            mvb = (mt == 6 * HT);
            if (mfs) mcnt = (mcnt + 1) % 4;
        end else begin
            mls = 0; mfs = 0; mvb = 0;
        end
        sbq.push_back(use_tbl ? texp : model_out());
        @(posedge clk);
        #1;
        got = mk(s_sx, s_sy, s_hs, s_vs, s_de, s_ls, s_fs, s_vb, s_cnt);
        exp = sbq.pop_front();
        check(use_tbl ? "small_table" : "small_cycle", 64'(got), 64'(exp));
        last = got;
        cyc++;
    endtask

    initial begin
        vec_t tbl[7];
        out_t z;
        int   fs_cyc[$];
        int   vb_n, k, cnt_hs;
        bit   found;

        z = '0;
        tbl[0] = '{rst: 1'b1, ce: 1'b0, exp: mk(15, 11, 1, 1, 0, 0, 0, 0, 0)};
        tbl[1] = '{rst: 1'b1, ce: 1'b1, exp: mk(15, 11, 1, 1, 0, 0, 0, 0, 0)};
        tbl[2] = '{rst: 1'b0, ce: 1'b0, exp: mk(15, 11, 1, 1, 0, 0, 0, 0, 0)};
        tbl[3] = '{rst: 1'b0, ce: 1'b1, exp: mk(0, 0, 1, 1, 1, 1, 1, 0, 1)};
        tbl[4] = '{rst: 1'b0, ce: 1'b0, exp: mk(0, 0, 1, 1, 1, 0, 0, 0, 1)};
        tbl[5] = '{rst: 1'b0, ce: 1'b1, exp: mk(1, 0, 1, 1, 1, 0, 0, 0, 1)};
        tbl[6] = '{rst: 1'b0, ce: 1'b1, exp: mk(2, 0, 1, 1, 1, 0, 0, 0, 1)};
        for (int i = 0; i < 7; i++)
            step_s(tbl[i].rst, tbl[i].ce, 1'b1, tbl[i].exp);

        // Continuous ce: frame period and one vblank strobe per frame.
        vb_n = 0;
        for (int i = 0; i < 2 * FR + 8; i++) begin
            step_s(1'b0, 1'b1, 1'b0, z);
            if (last.fs) fs_cyc.push_back(cyc);
            if (last.vb && fs_cyc.size() == 1) vb_n++;
        end
        check("small_fs_seen", 64'(fs_cyc.size() >= 2), 64'd1);
        if (fs_cyc.size() >= 2) check("small_frame_period", 64'(fs_cyc[1] - fs_cyc[0]), 64'(FR));
        check("small_vblank_per_frame", 64'(vb_n), 64'd1);

        // ce high one cycle in three.
        fs_cyc.delete();
        for (int i = 0; i < 2 * 3 * FR + 10; i++) begin
            step_s(1'b0, (i % 3) == 0, 1'b0, z);
            if (last.fs) fs_cyc.push_back(cyc);
        end
        check("ce3_fs_seen", 64'(fs_cyc.size() >= 2), 64'd1);
        if (fs_cyc.size() >= 2) check("ce3_frame_period", 64'(fs_cyc[1] - fs_cyc[0]), 64'(3 * FR));

        // Mid-frame reset held for two cycles.
        found = 0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            step_s(1'b0, 1'b1, 1'b0, z);
            found = (mt == 4 * HT + 5);
        end
        check("rst_mid_reached", 64'(found), 64'd1);
        step_s(1'b1, 1'b1, 1'b0, z);
        step_s(1'b1, 1'b1, 1'b0, z);
        check("rst_mid_state", 64'(last), 64'(mk(15, 11, 1, 1, 0, 0, 0, 0, 0)));
        step_s(1'b0, 1'b1, 1'b0, z);
        check("rst_restart", 64'(last), 64'(mk(0, 0, 1, 1, 1, 1, 1, 0, 1)));

        // Frame counter wrap with FW=2.
        k = 1;
        for (int i = 0; i < 4 * FR + 2; i++) begin
            step_s(1'b0, 1'b1, 1'b0, z);
            if (last.fs) begin
                k++;
                check("cnt_wrap", 64'(last.cnt), 64'(k % 4));
            end
        end
        check("cnt_wrap_frames", 64'(k), 64'd5);

        // Default 480p: reset levels, then the first line and start of the second.
        @(negedge clk); rst_d = 1'b1; ce_d = 1'b1;
        @(posedge clk); #1;
        check("def_reset", mkd(d_sx, d_sy, d_hs, d_vs, d_de, d_ls, d_fs, d_vb, d_cnt),
              mkd(799, 524, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk); rst_d = 1'b0; ce_d = 1'b1;
        cnt_hs = 0;
        for (int unsigned i = 0; i <= 800; i++) begin
            int unsigned sx;
            @(posedge clk); #1;
            sx = i % 800;
            check("def_line", mkd(d_sx, d_sy, d_hs, d_vs, d_de, d_ls, d_fs, d_vb, d_cnt),
                  mkd(sx, i / 800, !(sx >= 656 && sx < 752), 1, sx < 640, sx == 0, i == 0, 0, 1));
            if (!d_hs) cnt_hs++;
        end
        check("def_hsync_width", 64'(cnt_hs), 64'd96);
        @(negedge clk); ce_d = 1'b0;

        // 720p positive polarity: idle low after reset, hsync 1390..1429.
        @(negedge clk); rst_h = 1'b1; ce_h = 1'b0;
        @(posedge clk); #1;
        check("p720_reset", mkd(h_sx, h_sy, h_hs, h_vs, h_de, h_ls, h_fs, h_vb, h_cnt),
              mkd(1649, 749, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rst_h = 1'b0; ce_h = 1'b1;
        cnt_hs = 0;
        for (int unsigned i = 0; i <= 1650; i++) begin
            int unsigned sx;
            @(posedge clk); #1;
            sx = i % 1650;
            check("p720_line", mkd(h_sx, h_sy, h_hs, h_vs, h_de, h_ls, h_fs, h_vb, h_cnt),
                  mkd(sx, i / 1650, sx >= 1390 && sx < 1430, 0, sx < 1280, sx == 0, i == 0, 0, 1));
            if (h_hs) cnt_hs++;
        end
        check("p720_hsync_width", 64'(cnt_hs), 64'd40);
        @(negedge clk); ce_h = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
